// File: rtl/gain_ctrl_defs.sv
// gain_ctrl_defs -- source-index constants and run-counter helpers for the gain-path arbiter.
// Revision: 1.0
`default_nettype none

package gain_ctrl_defs;

  localparam logic SRC0      = 1'b0;
  localparam logic SRC1      = 1'b1;
  localparam int   RUN_CNT_W = 4;

  typedef logic [RUN_CNT_W-1:0] run_cnt_t;

  // Saturating increment so a lone source can be granted forever without wrap.
  function automatic run_cnt_t run_cnt_sat_inc(input run_cnt_t cnt, input run_cnt_t limit);
    return (cnt >= limit) ? limit : run_cnt_t'(cnt + 1'b1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/rr_grant2.sv
// rr_grant2 -- combinational two-source round-robin grant with bounded bursts.
// Revision: 1.0
`default_nettype none

module rr_grant2
  import gain_ctrl_defs::*;
#(
  parameter int BURST = 1
) (
  input  logic     valid0,
  input  logic     valid1,
  input  logic     last,
  input  run_cnt_t run_cnt,
  input  logic     load_ok,
  output logic     granted,
  output logic     g
);

  localparam run_cnt_t BURST_C = run_cnt_t'(BURST);

  always_comb begin
    granted = 1'b0;
    g       = SRC0;
    if (load_ok) begin
      case ({valid1, valid0})
        2'b01: begin
          granted = 1'b1;
          g       = SRC0;
        end
        2'b10: begin
          granted = 1'b1;
          g       = SRC1;
        end
        2'b11: begin
          // Stay on the current source until its run reaches BURST, then hand over.
          granted = 1'b1;
          g       = (run_cnt < BURST_C) ? last : ~last;
        end
        default: begin
          granted = 1'b0;
          g       = SRC0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/rr_sample_arb.sv
// rr_sample_arb -- two-source round-robin sample arbiter feeding a one-slot output register.
// Revision: 1.0
`default_nettype none

module rr_sample_arb
  import gain_ctrl_defs::*;
#(
  parameter int WIDTH = 8,
  parameter int BURST = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in0_valid,
  input  logic [WIDTH-1:0] in0_data,
  output logic             in0_ready,
  input  logic             in1_valid,
  input  logic [WIDTH-1:0] in1_data,
  output logic             in1_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             out_sel,
  input  logic             out_ready
);

  localparam run_cnt_t BURST_C = run_cnt_t'(BURST);

  logic             r_out_valid;
  logic [WIDTH-1:0] r_out_data;
  logic             r_out_sel;
  logic             r_last;
  run_cnt_t         r_run_cnt;

  logic w_load_ok;
  logic w_granted;
  logic w_g;

  // Clearing cycles never transfer, so the slot can also accept while being drained.
  assign w_load_ok = ~rst & ~flush & (~r_out_valid | out_ready);

  rr_grant2 #(
    .BURST   (BURST)
  ) u_grant (
    .valid0  (in0_valid),
    .valid1  (in1_valid),
    .last    (r_last),
    .run_cnt (r_run_cnt),
    .load_ok (w_load_ok),
    .granted (w_granted),
    .g       (w_g)
  );

  assign in0_ready = w_granted & (w_g == SRC0);
  assign in1_ready = w_granted & (w_g == SRC1);

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_sel   <= SRC0;
      r_last      <= SRC0;
      r_run_cnt   <= '0;
    end else if (w_granted) begin
      r_out_data  <= (w_g == SRC1) ? in1_data : in0_data;
      r_out_sel   <= w_g;
      r_out_valid <= 1'b1;
      if (w_g == r_last) begin
        r_run_cnt <= run_cnt_sat_inc(r_run_cnt, BURST_C);
      end else begin
        r_last    <= w_g;
        r_run_cnt <= run_cnt_t'(1);
      end
    end else if (out_ready && r_out_valid) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_sel   = r_out_sel;

endmodule

`default_nettype wire

// File: tb/tb_rr_sample_arb.sv
// tb_rr_sample_arb -- two arbiter instances (BURST=1 and BURST=3) checked against a behavioural model.
// Revision: 1.0
`default_nettype none

module tb_rr_sample_arb;

  localparam int W  = 8;
  localparam int BA = 1;
  localparam int BB = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst, flush, in0_valid, in1_valid, out_ready;
  logic [W-1:0] in0_data, in1_data;
  logic [1:0]   in0_ready, in1_ready, out_valid, out_sel;
  logic [W-1:0] out_data [2];

  rr_sample_arb #(.WIDTH(W), .BURST(BA)) dut_a (
    .clk(clk), .rst(rst), .flush(flush),
    .in0_valid(in0_valid), .in0_data(in0_data), .in0_ready(in0_ready[0]),
    .in1_valid(in1_valid), .in1_data(in1_data), .in1_ready(in1_ready[0]),
    .out_valid(out_valid[0]), .out_data(out_data[0]), .out_sel(out_sel[0]),
    .out_ready(out_ready)
  );

  rr_sample_arb #(.WIDTH(W), .BURST(BB)) dut_b (
    .clk(clk), .rst(rst), .flush(flush),
    .in0_valid(in0_valid), .in0_data(in0_data), .in0_ready(in0_ready[1]),
    .in1_valid(in1_valid), .in1_data(in1_data), .in1_ready(in1_ready[1]),
    .out_valid(out_valid[1]), .out_data(out_data[1]), .out_sel(out_sel[1]),
    .out_ready(out_ready)
  );

  int compared   = 0;
  int mismatched = 0;
  bit started    = 1'b0;

  // Model state: slot contents plus which source owns the current run and its length.
  bit           m_valid [2];
  logic [W-1:0] m_data  [2];
  bit           m_sel   [2];
  bit           m_last  [2];
  int           m_run   [2];
  int           burst_of[2] = '{BA, BB};

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic void model_grant(input int k, output bit gr, output bit g);
    gr = 1'b0;
    g  = 1'b0;
    if (rst || flush) return;
    if (m_valid[k] && !out_ready) return;
    if (in0_valid && in1_valid) begin
      gr = 1'b1;
      g  = (m_run[k] < burst_of[k]) ? m_last[k] : !m_last[k];
    end else if (in0_valid) begin
      gr = 1'b1;
      g  = 1'b0;
    end else if (in1_valid) begin
      gr = 1'b1;
      g  = 1'b1;
    end
  endfunction

  always @(posedge clk) begin
    if (rst) started = 1'b1;
    for (int k = 0; k < 2; k++) begin
      bit gr, g;
      model_grant(k, gr, g);
      if (rst || flush) begin
        m_valid[k] = 1'b0;
        m_data[k]  = '0;
        m_sel[k]   = 1'b0;
        m_last[k]  = 1'b0;
        m_run[k]   = 0;
      end else if (gr) begin
        m_data[k]  = g ? in1_data : in0_data;
        m_sel[k]   = g;
        m_valid[k] = 1'b1;
        if (g == m_last[k]) begin
          m_run[k]++;
        end else begin
          m_last[k] = g;
          m_run[k]  = 1;
        end
      end else if (out_ready && m_valid[k]) begin
        m_valid[k] = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (started) begin
      for (int k = 0; k < 2; k++) begin
        bit gr, g;
        model_grant(k, gr, g);
        chk($sformatf("out_valid[%0d]", k), 32'(out_valid[k]), 32'(m_valid[k]));
        chk($sformatf("out_data[%0d]", k),  32'(out_data[k]),  32'(m_data[k]));
        chk($sformatf("out_sel[%0d]", k),   32'(out_sel[k]),   32'(m_sel[k]));
        chk($sformatf("in0_ready[%0d]", k), 32'(in0_ready[k]), 32'(gr && !g));
        chk($sformatf("in1_ready[%0d]", k), 32'(in1_ready[k]), 32'(gr && g));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [7:0]  p1_data [3] = '{8'h11, 8'h22, 8'h33};
  logic [10:0] exp_sel_a   = 11'h2AA;
  logic [10:0] exp_sel_b   = 11'h238;

  initial begin
    rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
    in0_valid = 1'b0; in1_valid = 1'b0; in0_data = '0; in1_data = '0;
    step();
    step();
    chk("reset out_valid", 32'(out_valid), 32'h0);
    chk("reset out_sel", 32'(out_sel), 32'h0);
    chk("reset readies", 32'({in0_ready, in1_ready}), 32'h0);
    rst = 1'b0;

    // Lone source 0 streaming three words.
    out_ready = 1'b1;
    in0_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in0_data = p1_data[i];
      #2;
      chk("p1 readies", 32'({in0_ready, in1_ready}), 32'b1100);
      step();
      chk("p1 out_data a", 32'(out_data[0]), 32'(p1_data[i]));
      chk("p1 out_data b", 32'(out_data[1]), 32'(p1_data[i]));
      chk("p1 out_sel", 32'(out_sel), 32'h0);
      chk("p1 out_valid", 32'(out_valid), 32'h3);
    end
    in0_valid = 1'b0;
    step();
    chk("p1 drained", 32'(out_valid), 32'h0);

    // Both valid: BURST=1 alternates, BURST=3 runs three; in1 drops mid-burst at i=10.
    rst = 1'b1;
    step();
    rst = 1'b0;
    in0_valid = 1'b1;
    for (int i = 0; i < 11; i++) begin
      in0_data  = 8'hA0 + 8'(i);
      in1_data  = 8'hB0 + 8'(i);
      in1_valid = (i != 10);
      step();
      chk("p2 sel a", 32'(out_sel[0]), 32'(exp_sel_a[i]));
      chk("p2 sel b", 32'(out_sel[1]), 32'(exp_sel_b[i]));
      chk("p2 valid", 32'(out_valid), 32'h3);
      chk("p2 data a", 32'(out_data[0]), 32'((exp_sel_a[i] ? 8'hB0 : 8'hA0) + 8'(i)));
      chk("p2 data b", 32'(out_data[1]), 32'((exp_sel_b[i] ? 8'hB0 : 8'hA0) + 8'(i)));
    end

    // Stalled sink with both sources pending.
    in1_valid = 1'b1;
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in0_data = 8'hC0 + 8'(i);
      in1_data = 8'hD0 + 8'(i);
      #2;
      chk("p3 stall readies", 32'({in0_ready, in1_ready}), 32'h0);
      step();
      chk("p3 stall data a", 32'(out_data[0]), 32'hAA);
      chk("p3 stall data b", 32'(out_data[1]), 32'hAA);
      chk("p3 stall valid", 32'(out_valid), 32'h3);
    end
    in0_data  = 8'hE0;
    in1_data  = 8'hF0;
    out_ready = 1'b1;
    #2;
    chk("p3 release in0_ready", 32'(in0_ready), 32'b10);
    chk("p3 release in1_ready", 32'(in1_ready), 32'b01);
    step();
    chk("p3 reload valid", 32'(out_valid), 32'h3);
    chk("p3 reload data a", 32'(out_data[0]), 32'hF0);
    chk("p3 reload data b", 32'(out_data[1]), 32'hE0);

    // Reset while a source-1 word is held.
    in0_valid = 1'b0;
    in1_data  = 8'h5A;
    step();
    chk("p4 pre sel", 32'(out_sel), 32'h3);
    rst = 1'b1;
    out_ready = 1'b0;
    #2;
    chk("p4 rst readies", 32'({in0_ready, in1_ready}), 32'h0);
    step();
    chk("p4 rst valid", 32'(out_valid), 32'h0);
    chk("p4 rst sel", 32'(out_sel), 32'h0);
    rst = 1'b0;
    in0_valid = 1'b1;
    out_ready = 1'b1;
    #2;
    chk("p4 first grant", 32'({in0_ready, in1_ready}), 32'b1100);
    step();
    chk("p4 first sel", 32'(out_sel), 32'h0);

    // Flush with a pending word and a stalled sink.
    in1_valid = 1'b0;
    in0_data  = 8'h77;
    step();
    out_ready = 1'b0;
    flush = 1'b1;
    in1_valid = 1'b1;
    #2;
    chk("p5 flush readies", 32'({in0_ready, in1_ready}), 32'h0);
    step();
    chk("p5 flush valid", 32'(out_valid), 32'h0);
    flush = 1'b0;
    out_ready = 1'b1;
    #2;
    chk("p5 resume grant", 32'({in0_ready, in1_ready}), 32'b1100);
    step();
    chk("p5 resume valid", 32'(out_valid), 32'h3);

    // Randomized traffic with shifting source and sink biases.
    for (int seg = 0; seg < 8; seg++) begin
      int b0, b1, bo;
      b0 = $urandom_range(0, 4);
      b1 = $urandom_range(0, 4);
      bo = $urandom_range(0, 4);
      for (int i = 0; i < 500; i++) begin
        rst       = ($urandom_range(0, 199) == 0);
        flush     = ($urandom_range(0, 63) == 0);
        in0_valid = ($urandom_range(0, 4) >= b0);
        in1_valid = ($urandom_range(0, 4) >= b1);
        out_ready = ($urandom_range(0, 4) >= bo);
        in0_data  = 8'($urandom);
        in1_data  = 8'($urandom);
        step();
      end
    end

    rst = 1'b0; flush = 1'b0;
    step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

`default_nettype wire
